int_execution_unit: RTL

INT_EXECUTION_UNIT -- requirements
Module: int_execution_unit

---
 rtl/int_execution_unit_pkg.sv | 60 ++++++
 rtl/int_execution_unit_alu.sv | 45 ++++
 rtl/int_execution_unit.sv | 56 +++++
 3 files changed

// File: rtl/int_execution_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_execution_unit_pkg
// Description : Shared opcodes, ALU operation enum, result-buffer struct and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package int_execution_unit_pkg;

    localparam logic [6:0] C_OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] C_OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] C_OPC_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS,
        ALU_ZERO
    } alu_op_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  tag;
        logic [31:0] data;
    } result_buf_t;

    // I-type never subtracts: funct7[5] of an ADDI is immediate bits, not a SUB select.
    function automatic alu_op_t decode_alu_op(
        input logic [6:0] opcode,
        input logic [2:0] funct3,
        input logic       funct7_b5
    );
        alu_op_t op;
        op = ALU_ZERO;
        if (opcode == C_OPC_LUI) begin
            op = ALU_PASS;
        end else if (opcode == C_OPC_RTYPE || opcode == C_OPC_ITYPE) begin
            case (funct3)
                3'b000:  op = (opcode == C_OPC_RTYPE && funct7_b5) ? ALU_SUB : ALU_ADD;
                3'b001:  op = ALU_SLL;
                3'b010:  op = ALU_SLT;
                3'b011:  op = ALU_SLTU;
                3'b100:  op = ALU_XOR;
                3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
                3'b110:  op = ALU_OR;
                default: op = ALU_AND;
            endcase
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_execution_unit_alu.sv
`default_nettype none
// ============================================================================
// Module      : int_alu
// Description : Purely combinational 32-bit integer ALU for R-type, I-type and LUI.
// Revision    : 1.0 - initial release
// ============================================================================
module int_alu
    import int_execution_unit_pkg::*;
(
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [31:0] result
);

    alu_op_t     w_op;
    logic [4:0]  w_shamt;
    logic        w_unused_funct7;

    assign w_op            = decode_alu_op(opcode, funct3, funct7[5]);
    assign w_shamt         = rt_data[4:0];
    assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        result = 32'd0;
        case (w_op)
            ALU_ADD:  result = rs_data + rt_data;
            ALU_SUB:  result = rs_data - rt_data;
            ALU_SLL:  result = rs_data << w_shamt;
            ALU_SLT:  result = {31'd0, $signed(rs_data) < $signed(rt_data)};
            ALU_SLTU: result = {31'd0, rs_data < rt_data};
            ALU_XOR:  result = rs_data ^ rt_data;
            ALU_SRL:  result = rs_data >> w_shamt;
            ALU_SRA:  result = $unsigned($signed(rs_data) >>> w_shamt);
            ALU_OR:   result = rs_data | rt_data;
            ALU_AND:  result = rs_data & rt_data;
            ALU_PASS: result = rt_data;
            default:  result = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/int_execution_unit.sv
`default_nettype none
// ============================================================================
// Module      : int_execution_unit
// Description : Integer execution unit with a single-entry CDB result buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module int_execution_unit
    import int_execution_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        issueque_ready,
    input  logic [31:0] issueque_rs_data,
    input  logic [31:0] issueque_rt_data,
    input  logic [5:0]  issueque_rd_tag,
    input  logic [6:0]  issueque_opcode,
    input  logic [2:0]  issueque_funct3,
    input  logic [6:0]  issueque_funct7,
    output logic        issueblk_done,
    output logic        int_cdb_req,
    output logic [5:0]  int_cdb_tag,
    output logic [31:0] int_cdb_data,
    input  logic        cdb_grant
);

    result_buf_t r_buf;
    logic [31:0] w_alu_result;

    int_alu u_alu (
        .rs_data (issueque_rs_data),
        .rt_data (issueque_rt_data),
        .opcode  (issueque_opcode),
        .funct3  (issueque_funct3),
        .funct7  (issueque_funct7),
        .result  (w_alu_result)
    );

    // A grant frees the slot in the same cycle, so accept and drain can overlap.
    assign issueblk_done = !reset && issueque_ready && (!r_buf.valid || cdb_grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf <= '0;
        end else if (issueblk_done) begin
            r_buf <= '{valid: 1'b1, tag: issueque_rd_tag, data: w_alu_result};
        end else if (cdb_grant) begin
            r_buf.valid <= 1'b0;
        end
    end

    assign int_cdb_req  = r_buf.valid;
    assign int_cdb_tag  = r_buf.tag;
    assign int_cdb_data = r_buf.data;

endmodule
`default_nettype wire
